// File: rtl/donor_search.sv
// rtl/donor_search.sv - blood donor registry with sequential lowest-index compatible-donor search
// Eight-slot registry; a request scans slots 0..7 one per edge and reports the first compatible donor.
module donor_search (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld_en,
   input  logic [2:0] ld_idx,
   input  logic       ld_present,
   input  logic       ld_a,
   input  logic       ld_b,
   input  logic       ld_rh,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       pat_a,
   input  logic       pat_b,
   input  logic       pat_rh,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_found,
   output logic [2:0] rsp_idx,
   output logic [3:0] avail_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0] state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic       pat_a_q, pat_a_d;
   logic       pat_b_q, pat_b_d;
   logic       pat_rh_q, pat_rh_d;
   logic       found_q, found_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] present_q, present_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] rh_q, rh_d;
   logic       cur_match;
   logic [3:0] cnt;

   // Evaluation always uses registry contents from before the edge.
   always_comb begin
      cur_match = present_q[ptr_q]
                & (~a_q[ptr_q]  | pat_a_q)
                & (~b_q[ptr_q]  | pat_b_q)
                & (~rh_q[ptr_q] | pat_rh_q);
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      pat_a_d   = pat_a_q;
      pat_b_d   = pat_b_q;
      pat_rh_d  = pat_rh_q;
      found_d   = found_q;
      idx_d     = idx_q;
      present_d = present_q;
      a_d       = a_q;
      b_d       = b_q;
      rh_d      = rh_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               pat_a_d  = pat_a;
               pat_b_d  = pat_b;
               pat_rh_d = pat_rh;
               ptr_d    = 3'd0;
               state_d  = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (cur_match) begin
               state_d = ST_RESP;
               found_d = 1'b1;
               idx_d   = ptr_q;
            end else if (ptr_q == 3'd7) begin
               state_d = ST_RESP;
               found_d = 1'b0;
               idx_d   = 3'd0;
            end else begin
               ptr_d = ptr_q + 3'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
               if (found_q) begin
                  present_d[idx_q] = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Applied after the consume-clear so a same-slot load overrides it.
      if (ld_en) begin
         present_d[ld_idx] = ld_present;
         a_d[ld_idx]       = ld_a;
         b_d[ld_idx]       = ld_b;
         rh_d[ld_idx]      = ld_rh;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'd0;
         pat_a_q   <= 1'b0;
         pat_b_q   <= 1'b0;
         pat_rh_q  <= 1'b0;
         found_q   <= 1'b0;
         idx_q     <= 3'd0;
         present_q <= 8'd0;
         a_q       <= 8'd0;
         b_q       <= 8'd0;
         rh_q      <= 8'd0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         pat_a_q   <= pat_a_d;
         pat_b_q   <= pat_b_d;
         pat_rh_q  <= pat_rh_d;
         found_q   <= found_d;
         idx_q     <= idx_d;
         present_q <= present_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rh_q      <= rh_d;
      end
   end

   always_comb begin
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'd0, present_q[i]};
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_found = found_q;
   assign rsp_idx   = idx_q;
   assign avail_cnt = cnt;

endmodule

// File: tb/tb_donor_search.sv
// tb/tb_donor_search.sv - directed self-checking bench for donor_search
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_donor_search;

   logic       clk;
   logic       rst_n;
   logic       ld_en;
   logic [2:0] ld_idx;
   logic       ld_present;
   logic       ld_a;
   logic       ld_b;
   logic       ld_rh;
   logic       req_valid;
   logic       req_ready;
   logic       pat_a;
   logic       pat_b;
   logic       pat_rh;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_found;
   logic [2:0] rsp_idx;
   logic [3:0] avail_cnt;

   int checks;
   int errors;

   donor_search dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_en     (ld_en),
      .ld_idx    (ld_idx),
      .ld_present(ld_present),
      .ld_a      (ld_a),
      .ld_b      (ld_b),
      .ld_rh     (ld_rh),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .pat_a     (pat_a),
      .pat_b     (pat_b),
      .pat_rh    (pat_rh),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_found (rsp_found),
      .rsp_idx   (rsp_idx),
      .avail_cnt (avail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_load(input logic [2:0] idx, input logic pr, input logic a, input logic b, input logic rh);
      ld_en      = 1'b1;
      ld_idx     = idx;
      ld_present = pr;
      ld_a       = a;
      ld_b       = b;
      ld_rh      = rh;
   endtask

   task automatic load_slot(input logic [2:0] idx, input logic pr, input logic a, input logic b, input logic rh);
      drive_load(idx, pr, a, b, rh);
      tick();
      ld_en = 1'b0;
   endtask

   // Accept edge, then count edges until rsp_valid (bounded).
   task automatic do_request(input logic a, input logic b, input logic rh, output int lat);
      req_valid = 1'b1;
      pat_a     = a;
      pat_b     = b;
      pat_rh    = rh;
      tick();
      req_valid = 1'b0;
      pat_a     = 1'b0;
      pat_b     = 1'b0;
      pat_rh    = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      checks++;
      if ({req_ready, rsp_valid, rsp_found, rsp_idx} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_outputs: got %b required %b", {req_ready, rsp_valid, rsp_found, rsp_idx}, 6'b100000);
      end
      checks++;
      if (avail_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_avail: got %0d required 0", avail_cnt);
      end
   endtask

   task automatic test_single_match;
      int lat;
      load_slot(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (avail_cnt !== 4'd1) begin
         errors++;
         $display("FAIL single_avail_load: got %0d required 1", avail_cnt);
      end
      do_request(1'b1, 1'b1, 1'b1, lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL single_latency: got %0d required 4", lat);
      end
      checks++;
      if ({rsp_found, rsp_idx} !== 4'b1011) begin
         errors++;
         $display("FAIL single_result: got %b required %b", {rsp_found, rsp_idx}, 4'b1011);
      end
      consume();
      checks++;
      if ({req_ready, rsp_valid, avail_cnt} !== 6'b100000) begin
         errors++;
         $display("FAIL single_consume: got %b required %b", {req_ready, rsp_valid, avail_cnt}, 6'b100000);
      end
   endtask

   task automatic test_rh_and_miss;
      int lat;
      load_slot(3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      load_slot(3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      do_request(1'b1, 1'b0, 1'b0, lat);
      checks++;
      if (lat !== 6 || {rsp_found, rsp_idx} !== 4'b1101) begin
         errors++;
         $display("FAIL rh_reject: got lat %0d res %b required lat 6 res %b", lat, {rsp_found, rsp_idx}, 4'b1101);
      end
      consume();
      checks++;
      if (avail_cnt !== 4'd1) begin
         errors++;
         $display("FAIL rh_consume_avail: got %0d required 1", avail_cnt);
      end
      do_request(1'b0, 1'b1, 1'b1, lat);
      checks++;
      if (lat !== 8 || {rsp_found, rsp_idx} !== 4'b0000) begin
         errors++;
         $display("FAIL miss_result: got lat %0d res %b required lat 8 res %b", lat, {rsp_found, rsp_idx}, 4'b0000);
      end
      consume();
      checks++;
      if (avail_cnt !== 4'd1) begin
         errors++;
         $display("FAIL miss_no_clear: got %0d required 1", avail_cnt);
      end
      load_slot(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (avail_cnt !== 4'd0) begin
         errors++;
         $display("FAIL clear_by_load: got %0d required 0", avail_cnt);
      end
   endtask

   task automatic test_hold;
      int lat;
      load_slot(3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      load_slot(3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
      do_request(1'b1, 1'b1, 1'b1, lat);
      checks++;
      if (lat !== 2 || {rsp_found, rsp_idx} !== 4'b1001) begin
         errors++;
         $display("FAIL lowest_wins: got lat %0d res %b required lat 2 res %b", lat, {rsp_found, rsp_idx}, 4'b1001);
      end
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         pat_a     = i[0];
         pat_b     = i[1];
         pat_rh    = 1'b0;
         tick();
         checks++;
         if ({req_ready, rsp_valid, rsp_found, rsp_idx} !== 6'b011001) begin
            errors++;
            $display("FAIL hold_cycle%0d: got %b required %b", i, {req_ready, rsp_valid, rsp_found, rsp_idx}, 6'b011001);
         end
      end
      req_valid = 1'b0;
      consume();
      checks++;
      if (avail_cnt !== 4'd1) begin
         errors++;
         $display("FAIL hold_consume_avail: got %0d required 1", avail_cnt);
      end
      load_slot(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_load_during_scan;
      int edges;
      req_valid = 1'b1;
      pat_a     = 1'b1;
      pat_b     = 1'b0;
      pat_rh    = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      // Edge that evaluates ptr=2: a load to slot2 must not be matched.
      drive_load(3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive_load(3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      ld_en = 1'b0;
      edges = 4;
      while (!rsp_valid && edges < 20) begin
         tick();
         edges++;
      end
      checks++;
      if (edges !== 5 || {rsp_found, rsp_idx} !== 4'b1100) begin
         errors++;
         $display("FAIL scan_load: got lat %0d res %b required lat 5 res %b", edges, {rsp_found, rsp_idx}, 4'b1100);
      end
      checks++;
      if (avail_cnt !== 4'd2) begin
         errors++;
         $display("FAIL scan_load_avail: got %0d required 2", avail_cnt);
      end
      consume();
      load_slot(3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (avail_cnt !== 4'd0) begin
         errors++;
         $display("FAIL scan_load_cleanup: got %0d required 0", avail_cnt);
      end
   endtask

   task automatic test_load_wins;
      int lat;
      load_slot(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      do_request(1'b1, 1'b1, 1'b1, lat);
      checks++;
      if ({rsp_found, rsp_idx} !== 4'b1011) begin
         errors++;
         $display("FAIL lw_first: got %b required %b", {rsp_found, rsp_idx}, 4'b1011);
      end
      drive_load(3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      ld_en     = 1'b0;
      checks++;
      if (avail_cnt !== 4'd1) begin
         errors++;
         $display("FAIL lw_avail: got %0d required 1", avail_cnt);
      end
      do_request(1'b1, 1'b0, 1'b1, lat);
      checks++;
      if (lat !== 8 || rsp_found !== 1'b0) begin
         errors++;
         $display("FAIL lw_not_a: got lat %0d found %b required lat 8 found 0", lat, rsp_found);
      end
      consume();
      do_request(1'b0, 1'b1, 1'b1, lat);
      checks++;
      if (lat !== 4 || {rsp_found, rsp_idx} !== 4'b1011) begin
         errors++;
         $display("FAIL lw_is_bpos: got lat %0d res %b required lat 4 res %b", lat, {rsp_found, rsp_idx}, 4'b1011);
      end
      consume();
      checks++;
      if (avail_cnt !== 4'd0) begin
         errors++;
         $display("FAIL lw_final_avail: got %0d required 0", avail_cnt);
      end
   endtask

   task automatic test_async_reset;
      int lat;
      load_slot(3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      req_valid = 1'b1;
      pat_a     = 1'b0;
      pat_b     = 1'b0;
      pat_rh    = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, avail_cnt} !== 6'b100000) begin
         errors++;
         $display("FAIL async_reset: got %b required %b", {req_ready, rsp_valid, avail_cnt}, 6'b100000);
      end
      #1;
      rst_n = 1'b1;
      do_request(1'b1, 1'b1, 1'b1, lat);
      checks++;
      if (lat !== 8 || {rsp_found, rsp_idx} !== 4'b0000) begin
         errors++;
         $display("FAIL post_reset_req: got lat %0d res %b required lat 8 res %b", lat, {rsp_found, rsp_idx}, 4'b0000);
      end
      consume();
      checks++;
      if ({req_ready, avail_cnt} !== 5'b10000) begin
         errors++;
         $display("FAIL post_reset_idle: got %b required %b", {req_ready, avail_cnt}, 5'b10000);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      ld_en      = 1'b0;
      ld_idx     = 3'd0;
      ld_present = 1'b0;
      ld_a       = 1'b0;
      ld_b       = 1'b0;
      ld_rh      = 1'b0;
      req_valid  = 1'b0;
      pat_a      = 1'b0;
      pat_b      = 1'b0;
      pat_rh     = 1'b0;
      rsp_ready  = 1'b0;
      test_reset();
      test_single_match();
      test_rh_and_miss();
      test_hold();
      test_load_during_scan();
      test_load_wins();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/donor_search.md
DONOR_SEARCH -- requirements
Module: donor_search

Interface
REQ-001: NSLOT, 8, number of donor slots in the registry; fixed at 8, index width 3.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: ld_en  input  1  write strobe for one registry slot.
REQ-005: ld_idx  input  3  slot written by ld_en.
REQ-006: ld_present  input  1  1 = slot holds a donor, 0 = slot cleared.
REQ-007: ld_a, ld_b, ld_rh  input  1 each  donor antigen A, antigen B, Rh+.
REQ-008: req_valid  input  1  patient request valid.
REQ-009: req_ready  output  1  block accepts a request.
REQ-010: pat_a, pat_b, pat_rh  input  1 each  patient antigen A, antigen B, Rh+; sampled on request accept.
REQ-011: rsp_valid  output  1  search result valid.
REQ-012: rsp_ready  input  1  result consumed.
REQ-013: rsp_found  output  1  a compatible donor was found.
REQ-014: rsp_idx  output  3  slot of the found donor; 0 when rsp_found=0.
REQ-015: avail_cnt  output  4  number of present slots, range 0..8.

Function
REQ-016: Blood-type encoding: a=1,b=0 is A; a=0,b=1 is B; a=1,b=1 is AB; a=0,b=0 is O.
REQ-017: A donor is compatible iff (!d_a | p_a) & (!d_b | p_b) & (!d_rh | p_rh) and the slot is present.
REQ-018: The FSM has three states: IDLE, SCAN and RESP.
REQ-019: req_ready = (state == IDLE); a request is accepted on an edge with req_valid & req_ready.
REQ-020: On accept, the block latches the patient type, sets scan pointer = 0 and goes to SCAN.
REQ-021: SCAN, per edge: evaluate slot[ptr] with pre-edge registry contents.
- On a match, go to RESP with rsp_found=1 and rsp_idx=ptr.
- On no match with ptr=7, go to RESP with rsp_found=0 and rsp_idx=0.
- Otherwise ptr increments by 1.
REQ-022: Latency: a match at slot k gives rsp_valid high after the (k+1)th edge following accept; no match gives it after the 8th edge; the lowest-index compatible slot always wins.
REQ-023: rsp_valid = (state == RESP); rsp_found and rsp_idx hold stable while rsp_valid=1 and rsp_ready=0.
REQ-024: On an edge with rsp_valid & rsp_ready, go to IDLE; if rsp_found=1, clear slot rsp_idx to not present on that edge.
REQ-025: Loads are accepted in every state and take effect on the edge.
- A load to the slot being evaluated on the same edge does not affect that evaluation.
- A load to a slot not yet scanned is seen when the scan reaches it.
REQ-026: If a load and a consume-clear hit the same slot on the same edge, the load wins.
REQ-027: avail_cnt reflects the registry after each edge and changes only by the net effect of loads and clears.
REQ-028: The patient inputs are ignored outside the accept edge; req_valid is ignored outside IDLE.

Reset
REQ-029: While rst_n=0 the block is asynchronously forced to:
- state=IDLE, all slots not present with a=b=rh=0, ptr=0;
- req_ready=1, rsp_valid=0, rsp_found=0, rsp_idx=0, avail_cnt=0.
REQ-030: Reset asserted mid-SCAN or in RESP aborts the search with no response produced and no slot cleared.
REQ-031: The first request can be accepted on the first edge after rst_n deasserts.

Verification
REQ-032: Load slot3=O- only, request AB+ -> rsp_valid after the 4th edge, rsp_found=1, rsp_idx=3; after the consume edge avail_cnt=0.
REQ-033: Load slot0=A+, slot5=O-, request A- -> rsp_found=1, rsp_idx=5 (Rh+ donor rejected); request B+ with only slot0=A+ loaded -> rsp_found=0 after 8 edges.
REQ-034: Slots 1 and 6 both AB-, request AB+ -> rsp_idx=1; hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout.
REQ-035: During SCAN at ptr=2, load slot4=O- into an empty registry, request A+ -> rsp_found=1, rsp_idx=4; a load to slot2 on the edge that evaluates ptr=2 is not matched.
REQ-036: Consume edge for rsp_idx=3 with a simultaneous ld_en to slot3 (present, B+) -> slot3 stays present as B+ and avail_cnt is unchanged.
REQ-037: Assert rst_n=0 mid-SCAN -> req_ready=1, rsp_valid=0 and avail_cnt=0 immediately, without waiting for a clock edge.
